laser_host: RTL and testbench
=============================

LASER_HOST -- requirements
Module: laser_host

Interface
REQ-001 Parameter OBJ_NUM, default 40: number of points per job.
REQ-002 Parameter TIMEOUT, default 2047: maximum WAIT cycles before a job aborts.
REQ-003 Parameter RADIUS_SQ, default 16: squared coverage radius.
REQ-004 Port CLK  input  1  single clock; all logic SHALL be rising-edge triggered on it.
REQ-005 Port RST  input  1  reset; synchronous and active-high.
REQ-006 Port start  input  1  pulse that requests a job.
REQ-007 Port wr_en  input  1  point-memory write strobe.
REQ-008 Port wr_addr  input  6  point index, 0..OBJ_NUM-1.
REQ-009 Port wr_data  input  8  point, {y[7:4], x[3:0]}.
REQ-010 Port X  output  4  point x coordinate to the engine.
REQ-011 Port Y  output  4  point y coordinate to the engine.
REQ-012 Port LASER_RST  output  1  engine reset, active-high.
REQ-013 Ports C1X, C1Y, C2X, C2Y  input  4 each  engine result centers.
REQ-014 Port DONE  input  1  engine result strobe.
REQ-015 Port busy  output  1  job in progress.
REQ-016 Port result_valid  output  1  one-cycle job-complete pulse.
REQ-017 Ports r_c1x, r_c1y, r_c2x, r_c2y  output  4 each  captured centers.
REQ-018 Port cover_cnt  output  6  points covered by either captured circle.
REQ-019 Port timeout  output  1  last job aborted without DONE.

Function
REQ-020 The FSM SHALL use states IDLE, RST_ENG, SEND, WAIT, SCORE and REPORT, with REPORT returning to IDLE.
REQ-021 In IDLE, start SHALL move the FSM to RST_ENG; start in any other state SHALL be ignored.
REQ-022 RST_ENG SHALL last exactly 1 cycle, then move to SEND.
REQ-023 SEND SHALL last OBJ_NUM cycles; in SEND cycle k (k = 0..39), {Y,X} SHALL equal mem[k].
REQ-024 Outside SEND, X and Y SHALL be 0.
REQ-025 LASER_RST SHALL be 0 in SEND and WAIT and 1 in all other states, decoded from the registered state.
REQ-026 Consequently, the engine samples point 0 in the first cycle after LASER_RST falls.
REQ-027 In WAIT, DONE=1 SHALL capture C1X/C1Y/C2X/C2Y into r_c1x/r_c1y/r_c2x/r_c2y and move the FSM to SCORE.
REQ-028 DONE SHALL be ignored in every state other than WAIT.
REQ-029 An 11-bit WAIT counter SHALL clear on WAIT entry.
REQ-030 If the WAIT counter reaches TIMEOUT with DONE=0, the FSM SHALL go to REPORT with timeout=1, cover_cnt=0 and r_* = 0.
REQ-031 DONE=1 in the same cycle the counter reaches TIMEOUT SHALL count as success, not timeout.
REQ-032 SCORE SHALL last OBJ_NUM cycles, evaluating one point per cycle against both captured centers.
REQ-033 Point p SHALL count as covered when dx*dx+dy*dy <= RADIUS_SQ for C1 or for C2.
REQ-034 dx and dy SHALL be 4-bit absolute differences, each square SHALL be 8 bits, and the sum SHALL be 9 bits.
REQ-035 A point covered by both circles SHALL count once.
REQ-036 cover_cnt SHALL clear on SCORE entry, increment per covered point, and saturate at 40.
REQ-037 REPORT SHALL last 1 cycle with result_valid=1.
REQ-038 The result registers (r_*, cover_cnt, timeout) SHALL hold their values until the next accepted start, which SHALL clear timeout.
REQ-039 busy SHALL be 1 in RST_ENG, SEND, WAIT, SCORE and REPORT, and 0 in IDLE.
REQ-040 wr_en SHALL write mem[wr_addr] only when busy=0; writes with wr_addr >= OBJ_NUM SHALL be dropped.
REQ-041 wr_en asserted together with start in IDLE SHALL complete the write before RST_ENG, so the job sends the new value.
REQ-042 Latency: start accepted in cycle t puts RST_ENG at t+1, SEND at t+2..t+41 and WAIT from t+42; result_valid SHALL pulse 41 cycles after the DONE capture cycle.

Reset
REQ-043 With RST=1, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-044 Reset values: X=Y=0, LASER_RST=1, busy=0, result_valid=0, r_*=0, cover_cnt=0, timeout=0.
REQ-045 Point memory SHALL reset to all 0.
REQ-046 RST asserted mid-job SHALL abort the job within one cycle, with no result_valid pulse.

Verification
REQ-047 Reset check: assert RST, then release -> all REQ-044 values present; LASER_RST=1; X=Y=0.
REQ-048 Send order: load mem[k] = {k[3:0], k[3:0]}, start at cycle t -> LASER_RST=0 from t+2; {Y,X} = 8'h00, 8'h11, ... over 40 cycles; X=Y=0 at t+42.
REQ-049 Scoring: load all points (5,5); model returns C1=(5,9), C2=(15,15) -> cover_cnt=40, since dy=4 gives a squared distance of 16.
REQ-050 Scoring boundary: points (7,8) (d²=13) and (8,8) (d²=18) against C1=(5,5), C2=(0,15); all remaining 38 points (15,0) -> cover_cnt=1.
REQ-051 Timeout: model never raises DONE -> result_valid exactly TIMEOUT cycles after WAIT entry; timeout=1, cover_cnt=0.
REQ-052 Ignore checks: start and wr_en during SEND, and DONE pulsed during SCORE -> no restart, memory unchanged, captured centers unchanged.

Source files
------------

// File: rtl/laser_host_if.sv
// Bundles the job-control, point-load, engine and result signals of laser_host.
// The master side drives commands and engine results; the slave side is the host itself.
interface laser_host_if;
    logic       start;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    logic [3:0] X;
    logic [3:0] Y;
    logic       LASER_RST;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic       DONE;

    logic       busy;
    logic       result_valid;
    logic [3:0] r_c1x;
    logic [3:0] r_c1y;
    logic [3:0] r_c2x;
    logic [3:0] r_c2y;
    logic [5:0] cover_cnt;
    logic       timeout;

    modport master (
        output start, wr_en, wr_addr, wr_data, C1X, C1Y, C2X, C2Y, DONE,
        input  X, Y, LASER_RST, busy, result_valid,
               r_c1x, r_c1y, r_c2x, r_c2y, cover_cnt, timeout
    );

    modport slave (
        input  start, wr_en, wr_addr, wr_data, C1X, C1Y, C2X, C2Y, DONE,
        output X, Y, LASER_RST, busy, result_valid,
               r_c1x, r_c1y, r_c2x, r_c2y, cover_cnt, timeout
    );
endinterface

// File: rtl/laser_host.sv
// Laser engine host: streams stored points to the engine, waits for its two
// circle centers, then scores how many points fall inside either circle.
module laser_host #(
    parameter int OBJ_NUM   = 40,
    parameter int TIMEOUT   = 2047,
    parameter int RADIUS_SQ = 16
) (
    input logic         CLK,
    input logic         RST,
    laser_host_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        RST_ENG,
        SEND,
        WAIT,
        SCORE,
        REPORT
    } state_t;

    localparam logic [5:0]  LAST_IDX = 6'(OBJ_NUM - 1);
    localparam logic [5:0]  CNT_MAX  = 6'(OBJ_NUM);
    localparam logic [6:0]  ADDR_LIM = 7'(OBJ_NUM);
    localparam logic [10:0] TMO_LIM  = 11'(TIMEOUT);
    localparam logic [8:0]  RAD_SQ   = 9'(RADIUS_SQ);

    state_t      state;
    logic [5:0]  idx;
    logic [10:0] wcnt;
    logic [7:0]  mem [OBJ_NUM];
    logic [3:0]  c1x, c1y, c2x, c2y;
    logic [5:0]  cnt;
    logic        tmo;
    logic [7:0]  cur_pt;
    logic        covered;
    logic        wr_ok;

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        logic signed [4:0] d;
        logic signed [4:0] n;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        n = -d;
        return d[4] ? n[3:0] : d[3:0];
    endfunction

    // Squared distance kept at 9 bits so two 8-bit squares never wrap.
    function automatic logic in_circle(input logic [7:0] pt, input logic [3:0] cx,
                                       input logic [3:0] cy);
        logic [3:0] dx, dy;
        logic [7:0] sx, sy;
        logic [8:0] s;
        dx = abs_diff(pt[3:0], cx);
        dy = abs_diff(pt[7:4], cy);
        sx = {4'b0, dx} * {4'b0, dx};
        sy = {4'b0, dy} * {4'b0, dy};
        s  = {1'b0, sx} + {1'b0, sy};
        return s <= RAD_SQ;
    endfunction

    function automatic logic [5:0] sat_inc(input logic [5:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 6'd1;
    endfunction

    assign cur_pt  = mem[idx];
    assign covered = in_circle(cur_pt, c1x, c1y) || in_circle(cur_pt, c2x, c2y);
    assign wr_ok   = bus.wr_en && (state == IDLE) && ({1'b0, bus.wr_addr} < ADDR_LIM);

    // Writes land on the same edge that accepts start, so the job sees them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < OBJ_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            idx   <= '0;
            wcnt  <= '0;
            c1x   <= '0;
            c1y   <= '0;
            c2x   <= '0;
            c2y   <= '0;
            cnt   <= '0;
            tmo   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tmo   <= 1'b0;
                        state <= RST_ENG;
                    end
                end
                RST_ENG: begin
                    idx   <= '0;
                    state <= SEND;
                end
                SEND: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        wcnt  <= '0;
                        state <= WAIT;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                WAIT: begin
                    wcnt <= wcnt + 11'd1;
                    // DONE wins over an expiring counter in the same cycle.
                    if (bus.DONE) begin
                        c1x   <= bus.C1X;
                        c1y   <= bus.C1Y;
                        c2x   <= bus.C2X;
                        c2y   <= bus.C2Y;
                        cnt   <= '0;
                        idx   <= '0;
                        state <= SCORE;
                    end else if (wcnt + 11'd1 == TMO_LIM) begin
                        c1x   <= '0;
                        c1y   <= '0;
                        c2x   <= '0;
                        c2y   <= '0;
                        cnt   <= '0;
                        tmo   <= 1'b1;
                        state <= REPORT;
                    end
                end
                SCORE: begin
                    if (covered) begin
                        cnt <= sat_inc(cnt);
                    end
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= REPORT;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                REPORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.X            = (state == SEND) ? cur_pt[3:0] : 4'd0;
    assign bus.Y            = (state == SEND) ? cur_pt[7:4] : 4'd0;
    assign bus.LASER_RST    = !((state == SEND) || (state == WAIT));
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == REPORT);
    assign bus.r_c1x        = c1x;
    assign bus.r_c1y        = c1y;
    assign bus.r_c2x        = c2x;
    assign bus.r_c2y        = c2y;
    assign bus.cover_cnt    = cnt;
    assign bus.timeout      = tmo;
endmodule

// File: tb/tb_laser_host.sv
// Directed bench for laser_host: expected point streams and job results are
// queued by the driver and checked by independent negedge monitors.
module tb_laser_host;
    localparam int N   = 40;
    localparam int TMO = 2047;

    logic CLK = 1'b0;
    logic RST;
    int   cyc = 0;

    laser_host_if bus();

    laser_host dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] c1x, c1y, c2x, c2y;
        logic [5:0] cnt;
        logic       tmo;
    } res_t;

    res_t       res_q[$];
    logic [7:0] send_q[$];
    logic [7:0] model [N];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       abort_job = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Result scoreboard: one entry per expected result_valid pulse.
    res_t mon_e;
    always @(negedge CLK) begin
        if (RST === 1'b0 && bus.result_valid === 1'b1) begin
            if (res_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = res_q.pop_front();
                check("res_cycle", cyc, mon_e.cyc);
                check("res_c1x", bus.r_c1x, mon_e.c1x);
                check("res_c1y", bus.r_c1y, mon_e.c1y);
                check("res_c2x", bus.r_c2x, mon_e.c2x);
                check("res_c2y", bus.r_c2y, mon_e.c2y);
                check("res_cover", bus.cover_cnt, mon_e.cnt);
                check("res_timeout", bus.timeout, mon_e.tmo);
            end
        end
    end

    // Point-stream monitor: starts on the falling edge of LASER_RST.
    logic prev_lr = 1'b1;
    logic s_act   = 1'b0;
    logic s_ign   = 1'b0;
    int   s_k     = 0;
    logic [7:0] s_exp;
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            s_act = 1'b0;
        end else begin
            if (!s_act && bus.LASER_RST === 1'b0 && prev_lr) begin
                s_act = 1'b1;
                s_k   = 0;
                s_ign = abort_job;
            end
            if (s_act) begin
                if (bus.LASER_RST !== 1'b0) begin
                    s_act = 1'b0;
                    if (!s_ign) check("send_cut_short", s_k, N);
                end else if (s_k < N) begin
                    if (!s_ign) begin
                        if (send_q.size() == 0) begin
                            check("unexpected_send", 1, 0);
                        end else begin
                            s_exp = send_q.pop_front();
                            check("send_pt", {bus.Y, bus.X}, s_exp);
                        end
                    end
                    s_k++;
                end else begin
                    if (!s_ign) check("xy_after_send", {bus.Y, bus.X}, 0);
                    s_act = 1'b0;
                end
            end
        end
        prev_lr = bus.LASER_RST;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 6'(a);
        bus.wr_data = d;
        if (a < N) model[a] = d;
        step(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic start_job(output int t, input logic push_send);
        t = cyc;
        bus.start = 1'b1;
        if (push_send) begin
            for (int k = 0; k < N; k++) send_q.push_back(model[k]);
        end
        step(1);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        @(negedge CLK);
        check("lr_in_rst_eng", bus.LASER_RST, 1);
        check("busy_in_rst_eng", bus.busy, 1);
        check("timeout_cleared", bus.timeout, 0);
        step(1);
        @(negedge CLK);
        check("lr_low_first_send", bus.LASER_RST, 0);
    endtask

    task automatic run_done(input int t, input int delay, input logic [3:0] ax,
                            input logic [3:0] ay, input logic [3:0] bx,
                            input logic [3:0] by, input logic [5:0] cnt, output int rc);
        res_t e;
        goto(t + 42 + delay);
        check("busy_in_wait", bus.busy, 1);
        e.cyc = cyc + 41;
        e.c1x = ax; e.c1y = ay; e.c2x = bx; e.c2y = by;
        e.cnt = cnt;
        e.tmo = 1'b0;
        res_q.push_back(e);
        rc = e.cyc;
        bus.C1X = ax; bus.C1Y = ay; bus.C2X = bx; bus.C2Y = by;
        bus.DONE = 1'b1;
        step(1);
        bus.DONE = 1'b0;
        bus.C1X = ~ax; bus.C1Y = ~ay; bus.C2X = ~bx; bus.C2Y = ~by;
    endtask

    initial begin
        int   t;
        int   rc;
        res_t e;
        logic [3:0] n4;

        RST = 1'b1;
        bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.C1X = '0; bus.C1Y = '0; bus.C2X = '0; bus.C2Y = '0; bus.DONE = 1'b0;
        for (int k = 0; k < N; k++) model[k] = 8'h00;

        step(3);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_X", bus.X, 0);
        check("rst_Y", bus.Y, 0);
        check("rst_LASER_RST", bus.LASER_RST, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_result_valid", bus.result_valid, 0);
        check("rst_r_c1x", bus.r_c1x, 0);
        check("rst_r_c1y", bus.r_c1y, 0);
        check("rst_r_c2x", bus.r_c2x, 0);
        check("rst_r_c2y", bus.r_c2y, 0);
        check("rst_cover_cnt", bus.cover_cnt, 0);
        check("rst_timeout", bus.timeout, 0);
        step(1);

        // Job 1: ramp points (k,k); (0,0)/(15,15) cover i in {0,1,2,13,14,15} -> 15.
        for (int k = 0; k < N; k++) begin
            n4 = 4'(k);
            wr(k, {n4, n4});
        end
        wr(45, 8'hFF);
        start_job(t, 1'b1);
        run_done(t, 3, 4'd0, 4'd0, 4'd15, 4'd15, 6'd15, rc);
        goto(rc + 2);
        check("idle_after_report", bus.busy, 0);

        // Job 2: start/wr during SEND and a stray DONE in SCORE are ignored -> 25.
        start_job(t, 1'b1);
        goto(t + 10);
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 6'd39; bus.wr_data = 8'hFF;
        step(1);
        bus.start = 1'b0; bus.wr_en = 1'b0;
        run_done(t, 0, 4'd4, 4'd4, 4'd10, 4'd10, 6'd25, rc);
        goto(rc - 30);
        bus.C1X = 4'd15; bus.C1Y = 4'd15; bus.C2X = 4'd15; bus.C2Y = 4'd15;
        bus.DONE = 1'b1;
        step(1);
        bus.DONE = 1'b0;
        goto(rc + 2);

        // Job 3: all points (5,5), C1=(5,9) sits at exactly radius -> 40.
        for (int k = 0; k < N; k++) wr(k, 8'h55);
        start_job(t, 1'b1);
        run_done(t, 1, 4'd5, 4'd9, 4'd15, 4'd15, 6'd40, rc);
        goto(rc + 2);

        // Job 4: (7,8) d2=13 in, (8,8) d2=18 out, rest (15,0); last point written with start.
        wr(0, 8'h87);
        wr(1, 8'h88);
        for (int k = 2; k < N - 1; k++) wr(k, 8'h0F);
        bus.wr_en = 1'b1; bus.wr_addr = 6'd39; bus.wr_data = 8'h0F;
        model[39] = 8'h0F;
        start_job(t, 1'b1);
        run_done(t, 2, 4'd5, 4'd5, 4'd0, 4'd15, 6'd1, rc);
        goto(rc + 2);

        // Job 5: DONE on the last WAIT cycle still succeeds; (15,0) center covers 38.
        start_job(t, 1'b1);
        run_done(t, TMO - 1, 4'd15, 4'd0, 4'd0, 4'd0, 6'd38, rc);
        goto(rc + 2);

        // Job 6: engine never answers.
        start_job(t, 1'b1);
        e.cyc = t + 42 + TMO;
        e.c1x = 4'd0; e.c1y = 4'd0; e.c2x = 4'd0; e.c2y = 4'd0;
        e.cnt = 6'd0;
        e.tmo = 1'b1;
        res_q.push_back(e);
        goto(t + 42 + 100);
        check("lr_low_in_wait", bus.LASER_RST, 0);
        goto(e.cyc + 2);
        check("timeout_held", bus.timeout, 1);

        // Job 7: success after timeout; (8,8) center covers (8,8) and (7,8) -> 2.
        start_job(t, 1'b1);
        run_done(t, 4, 4'd8, 4'd8, 4'd15, 4'd15, 6'd2, rc);
        goto(rc + 2);
        check("results_held_c1x", bus.r_c1x, 8);
        check("results_held_cnt", bus.cover_cnt, 2);

        // Job 8: reset mid-SEND aborts without a result and clears memory.
        abort_job = 1'b1;
        start_job(t, 1'b0);
        goto(t + 10);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        @(negedge CLK);
        check("abort_busy", bus.busy, 0);
        check("abort_lr", bus.LASER_RST, 1);
        check("abort_xy", {bus.Y, bus.X}, 0);
        check("abort_r_c1x", bus.r_c1x, 0);
        check("abort_cover", bus.cover_cnt, 0);
        for (int k = 0; k < N; k++) model[k] = 8'h00;
        goto(t + 80);
        abort_job = 1'b0;

        // Job 9: memory is all zero after reset -> every point at C1 -> 40.
        start_job(t, 1'b1);
        run_done(t, 2, 4'd0, 4'd0, 4'd3, 4'd3, 6'd40, rc);
        goto(rc + 3);

        check("results_pending", res_q.size(), 0);
        check("sends_pending", send_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
